mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        qualifies mdu_op this cycle
//   mdu_op[2:0]  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, else no-op
//   A, B         operands (A is also the mthi/mtlo source)
//   busy         high while a multiply or divide is in flight
//   hi, lo       HI/LO registers
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               wr_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic               is_mul, is_div, sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;

    // The result is computed from the operands seen at the accept edge and
    // parked in res_q; the busy period only models latency.
    always_comb begin
        is_mul = mdu_op == 3'd1 || mdu_op == 3'd2;
        is_div = mdu_op == 3'd3 || mdu_op == 3'd4;
        sgn    = mdu_op == 3'd1 || mdu_op == 3'd3;
        ext_a  = sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        ext_b  = sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod   = ext_a * ext_b;
        a_neg  = sgn && A[WIDTH-1];
        b_neg  = sgn && B[WIDTH-1];
        // Magnitudes are unsigned, so the most-negative value maps onto
        // 2^(WIDTH-1) and the -min/-1 overflow falls out as LO=A, HI=0.
        mag_a  = a_neg ? -A : A;
        mag_b  = b_neg ? -B : B;
        quo    = mag_b == '0 ? '0 : mag_a / mag_b;
        rem    = mag_b == '0 ? '0 : mag_a % mag_b;
        res_d  = is_mul ? prod : {(a_neg ? -rem : rem), (a_neg ^ b_neg ? -quo : quo)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else if (state_q == IDLE) begin
            if (start && mdu_op == 3'd5)
                hi_q <= A;
            if (start && mdu_op == 3'd6)
                lo_q <= A;
            if (start && (is_mul || is_div)) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                cnt_q   <= is_mul ? MUL_LOAD : DIV_LOAD;
                res_q   <= res_d;
                // Divide by zero still runs the full period but commits nothing.
                wr_q    <= is_mul || B != '0;
            end
        end else if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (wr_q)
                {hi_q, lo_q} <= res_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
